// File: rtl/fet_mux_pkg.sv
// Shared definitions for the scanning channel multiplexer: state encoding,
// mode constants and the select-width helper.
package fet_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MANUAL = 2'b01,
        SCAN   = 2'b10
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fet_mux_n.sv
// Combinational CHANNELS-to-1 selector built as a binary tree of 2:1 muxes,
// one mux per tree node, so each node maps onto a single FET mux cell.
module fet_mux_n
    import fet_mux_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    localparam int SW      = sel_w(CHANNELS)
) (
    input  logic [WIDTH*CHANNELS-1:0] data,
    input  logic [SW-1:0]             sel,
    output logic [WIDTH-1:0]          y
);

    localparam int LEAVES = 1 << SW;

    // Heap layout: node 0 is the root, leaves sit at LEAVES-1 .. 2*LEAVES-2.
    logic [WIDTH-1:0] node [2*LEAVES-1];

    genvar i;
    generate
        for (i = 0; i < LEAVES; i++) begin : g_leaf
            if (i < CHANNELS) begin : g_used
                assign node[LEAVES-1+i] = data[i*WIDTH +: WIDTH];
            end else begin : g_pad
                assign node[LEAVES-1+i] = '0;
            end
        end
        for (i = 0; i < LEAVES-1; i++) begin : g_mux
            localparam int LVL = $clog2(i + 2) - 1;
            assign node[i] = sel[SW-1-LVL] ? node[2*i+2] : node[2*i+1];
        end
    endgenerate

    assign y = node[0];

endmodule

// File: rtl/fet_mux_scan.sv
// Registered channel multiplexer with manual select and an automatic
// round-robin scan mode that dwells DWELL enabled cycles per channel.
module fet_mux_scan
    import fet_mux_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 1,
    parameter int INVERT   = 0,
    localparam int SW      = sel_w(CHANNELS)
) (
    input  logic                      C,
    input  logic                      R,
    input  logic [WIDTH*CHANNELS-1:0] A,
    input  logic [SW-1:0]             S,
    input  logic                      M,
    input  logic                      E,
    output logic [WIDTH-1:0]          Y,
    output logic                      V,
    output logic [SW-1:0]             K
);

    localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
    localparam logic [SW:0]      CH_COUNT   = (SW+1)'(CHANNELS);
    localparam logic [SW-1:0]    K_LAST     = SW'(CHANNELS - 1);
    localparam logic [WIDTH-1:0] FLIP       = (INVERT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    state_t           state;
    logic [7:0]       dwell;
    logic [7:0]       dwell_now;
    logic [WIDTH-1:0] sel_data;

    fet_mux_n #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_mux (
        .data (A),
        .sel  (K),
        .y    (sel_data)
    );

    // Entering scan from any other state starts a fresh dwell on the current K.
    assign dwell_now = (state == SCAN) ? dwell : 8'd0;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state <= IDLE;
            Y     <= '0;
            V     <= 1'b0;
            K     <= '0;
            dwell <= '0;
        end else if (E) begin
            Y <= sel_data ^ FLIP;
            V <= 1'b1;
            if (M == MODE_MANUAL) begin
                state <= MANUAL;
                dwell <= '0;
                if ({1'b0, S} < CH_COUNT) begin
                    K <= S;
                end
            end else begin
                state <= SCAN;
                if (dwell_now == DWELL_LAST) begin
                    K     <= (K == K_LAST) ? '0 : K + SW'(1);
                    dwell <= '0;
                end else begin
                    dwell <= dwell_now + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fet_mux_scan.sv
// Self-checking bench: three differently configured instances share random
// stimulus and are compared every cycle against a behavioural model.
module tb_fet_mux_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] a_bus = '0;
    logic [2:0]  s_bus = '0;
    logic        mode = 1'b0;
    logic        en = 1'b0;
    logic        cmp_on = 1'b0;

    logic [3:0] y0, y1;
    logic [1:0] y2;
    logic       v0, v1, v2;
    logic [1:0] k0, k1;
    logic [2:0] k2;

    int checks = 0;
    int errors = 0;

    // Instance parameters: width, channels, dwell, invert.
    int pw[3]   = '{4, 4, 2};
    int pn[3]   = '{4, 3, 5};
    int pd[3]   = '{3, 2, 1};
    int pinv[3] = '{0, 0, 1};

    // Behavioural model state.
    int mk[3]   = '{0, 0, 0};
    int mcnt[3] = '{0, 0, 0};
    int my[3]   = '{0, 0, 0};
    int mv[3]   = '{0, 0, 0};

    fet_mux_scan #(.WIDTH(4), .CHANNELS(4), .DWELL(3), .INVERT(0)) u0 (
        .C(clk), .R(rst_n), .A(a_bus[15:0]), .S(s_bus[1:0]), .M(mode), .E(en),
        .Y(y0), .V(v0), .K(k0));
    fet_mux_scan #(.WIDTH(4), .CHANNELS(3), .DWELL(2), .INVERT(0)) u1 (
        .C(clk), .R(rst_n), .A(a_bus[11:0]), .S(s_bus[1:0]), .M(mode), .E(en),
        .Y(y1), .V(v1), .K(k1));
    fet_mux_scan #(.WIDTH(2), .CHANNELS(5), .DWELL(1), .INVERT(1)) u2 (
        .C(clk), .R(rst_n), .A(a_bus[9:0]), .S(s_bus[2:0]), .M(mode), .E(en),
        .Y(y2), .V(v2), .K(k2));

    always #5 clk = ~clk;

    function automatic int msk(int i);
        return (1 << pw[i]) - 1;
    endfunction

    function automatic int chan(int i, int c);
        return int'(a_bus >> (c * pw[i])) & msk(i);
    endfunction

    function automatic int sel_in(int i);
        return (i == 2) ? int'(s_bus) : int'(s_bus[1:0]);
    endfunction

    function automatic int act_y(int i);
        case (i)
            0:       return int'(y0);
            1:       return int'(y1);
            default: return int'(y2);
        endcase
    endfunction

    function automatic int act_v(int i);
        case (i)
            0:       return int'(v0);
            1:       return int'(v1);
            default: return int'(v2);
        endcase
    endfunction

    function automatic int act_k(int i);
        case (i)
            0:       return int'(k0);
            1:       return int'(k1);
            default: return int'(k2);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one channel sample per enabled cycle, manual or scan.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mk[i] <= 0; mcnt[i] <= 0; my[i] <= 0; mv[i] <= 0;
            end
        end else if (en) begin
            for (int i = 0; i < 3; i++) begin
                my[i] <= chan(i, mk[i]) ^ ((pinv[i] != 0) ? msk(i) : 0);
                mv[i] <= 1;
                if (!mode) begin
                    mcnt[i] <= 0;
                    if (sel_in(i) < pn[i]) mk[i] <= sel_in(i);
                end else if (mcnt[i] == pd[i] - 1) begin
                    mcnt[i] <= 0;
                    mk[i]   <= (mk[i] + 1) % pn[i];
                end else begin
                    mcnt[i] <= mcnt[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("u%0d_y", i), act_y(i), my[i]);
                check($sformatf("u%0d_v", i), act_v(i), mv[i]);
                check($sformatf("u%0d_k", i), act_k(i), mk[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int seq[7] = '{0, 1, 1, 2, 2, 0, 0};
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cmp_on = 1'b1;
        check("rst_y0", int'(y0), 0);
        check("rst_v0", int'(v0), 0);
        check("rst_k0", int'(k0), 0);
        check("rst_y2", int'(y2), 0);
        rst_n = 1'b1;

        // Manual select: K after one edge, data after two.
        a_bus = 16'hDCBA; mode = 1'b0; en = 1'b1; s_bus = 3'd2;
        tick();
        check("man_k_e1", int'(k0), 2);
        check("man_v_e1", int'(v0), 1);
        check("man_y_e1", int'(y0), 4'hA);
        tick();
        check("man_y_e2", int'(y0), 4'hC);

        // Asynchronous reset mid-run, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("async_y0", int'(y0), 0);
        check("async_v0", int'(v0), 0);
        check("async_k0", int'(k0), 0);
        mode = 1'b1; s_bus = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // Scan with wrap on the 3-channel, dwell-2 instance.
        check("scan_k_0", int'(k1), 0);
        for (int n = 0; n < 7; n++) begin
            tick();
            if (n == 0) check("scan_first_y", int'(y1), 4'hA);
            check($sformatf("scan_k_%0d", n + 1), int'(k1), seq[n]);
        end

        // Scan to manual and back: full dwell restarts from the manual K.
        pulse_reset();
        mode = 1'b1;
        tick();
        check("sw_k_a", int'(k0), 0);
        mode = 1'b0; s_bus = 3'd1;
        tick();
        check("sw_k_b", int'(k0), 1);
        mode = 1'b1;
        tick();
        check("sw_k_c", int'(k0), 1);
        tick();
        check("sw_k_d", int'(k0), 1);
        tick();
        check("sw_k_e", int'(k0), 2);

        // Out-of-range select holds K; disabled cycles hold everything.
        pulse_reset();
        mode = 1'b0; s_bus = 3'd1; a_bus = 16'h0CBA;
        tick();
        s_bus = 3'd3;
        tick();
        check("oor_k", int'(k1), 1);
        check("oor_y", int'(y1), 4'hB);
        en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            a_bus = 16'($urandom); s_bus = 3'($urandom); mode = 1'($urandom);
            tick();
            check("hold_k", int'(k1), 1);
            check("hold_y", int'(y1), 4'hB);
        end

        // Inverting instance, then reset forces zero regardless of INVERT.
        pulse_reset();
        en = 1'b1; mode = 1'b0; s_bus = 3'd1; a_bus = 16'h0004;
        tick();
        tick();
        check("inv_y", int'(y2), 2);
        #2 rst_n = 1'b0;
        #1;
        check("inv_rst_y", int'(y2), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            a_bus = 16'($urandom);
            s_bus = 3'($urandom);
            en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else tick();
        end

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
